// File: rtl/fetch_pkg.sv
// Shared opcode, state and instruction-field definitions for the fetch sequencer.
package fetch_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_OPER   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  function automatic logic [3:0] op_field(input logic [7:0] word);
    return word[7:4];
  endfunction

  function automatic logic [3:0] opnd_field(input logic [7:0] word);
    return word[3:0];
  endfunction

endpackage

// File: rtl/wait_cnt.sv
// Wait-state counter shared by FETCH and OPER; wraps to zero after LAST.
module wait_cnt #(
  parameter int unsigned WAIT_W = 3,
  parameter int unsigned LAST   = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic tc_nxt_o
);

  localparam logic [WAIT_W-1:0] LAST_C = WAIT_W'(LAST);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // next count: clear, advance with wrap, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + WAIT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o     = (cnt_q == LAST_C);
  // lets the owner register a pulse that lines up with the terminal cycle
  assign tc_nxt_o = (cnt_d == LAST_C);

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns pc/ir, decodes the tiny ISA and paces the
// address pipeline with wait states before each fetch and operand access.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_LAT = 3,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zero,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic       Ctl,
  output logic       rd_stb,
  output logic       wr_stb,
  output logic       halted,
  output logic [3:0] pc
);

  localparam int unsigned N = ADDR_LAT + MEM_LAT;

  logic [2:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       ctl_q, ctl_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       halted_q, halted_d;
  logic       cnt_clr, cnt_en, cnt_tc, cnt_tc_nxt;
  logic [3:0] op;

  assign op = op_field(ir_q);

  wait_cnt #(
    .WAIT_W (WAIT_W),
    .LAST   (N - 1)
  ) u_wait_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_o     (cnt_tc),
    .tc_nxt_o (cnt_tc_nxt)
  );

  // sequencing FSM with pc/ir updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          ir_d    = instr;
          pc_d    = pc_q + 4'd1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        cnt_clr = 1'b1;
        case (op)
          OP_NOP:  state_d = S_FETCH;
          OP_JMP: begin
            pc_d    = opnd_field(ir_q);
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (zero) pc_d = opnd_field(ir_q);
            else      pc_d = pc_q;
            state_d = S_FETCH;
          end
          OP_LD, OP_ST: state_d = S_OPER;
          OP_HALT:      state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_OPER: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = S_FETCH;
        else        state_d = S_OPER;
      end
      S_HALT: begin
        cnt_clr = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they arrive with state entry
  always_comb begin
    ctl_d    = (state_d == S_OPER);
    halted_d = (state_d == S_HALT);
    rd_d     = (state_d == S_OPER) && cnt_tc_nxt && (op == OP_LD);
    wr_d     = (state_d == S_OPER) && cnt_tc_nxt && (op == OP_ST);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 4'd0;
      ir_q     <= 8'd0;
      ctl_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
    end
  end

  assign D0     = pc_q;
  assign pc     = pc_q;
  assign D1     = opnd_field(ir_q);
  assign Ctl    = ctl_q;
  assign rd_stb = rd_q;
  assign wr_stb = wr_q;
  assign halted = halted_q;

endmodule
